// File: rtl/pkt_enq_framer_if.sv
// Bundles the upstream word stream and the processor enqueue port.
// master = framer side, slave = upstream source / processor side.
interface pkt_enq_framer_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 12
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              ram_full;
    logic              enq_req;
    logic              enq_in_sop;
    logic              enq_in_eop;
    logic [DATA_W-1:0] enq_wr_data_i;
    logic              enq_pck_len_valid;
    logic [LEN_W-1:0]  enq_pck_len_i;

    modport master (
        input  s_valid, s_data, s_last, ram_full,
        output s_ready, enq_req, enq_in_sop, enq_in_eop, enq_wr_data_i,
               enq_pck_len_valid, enq_pck_len_i
    );

    modport slave (
        output s_valid, s_data, s_last, ram_full,
        input  s_ready, enq_req, enq_in_sop, enq_in_eop, enq_wr_data_i,
               enq_pck_len_valid, enq_pck_len_i
    );
endinterface

// File: rtl/pkt_enq_framer.sv
// Store-and-forward framer: buffers one packet, then replays it on the enq bus
// with SOP/EOP/length; oversize packets are swallowed and counted.
module pkt_enq_framer #(
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 12,
    parameter int BUF_DEPTH = 64,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               sw_rst,
    pkt_enq_framer_if.master   bus,
    output logic [CNT_W-1:0]   pkt_sent_cnt,
    output logic [CNT_W-1:0]   pkt_drop_cnt,
    output logic               busy
);
    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    typedef enum logic [1:0] {COLLECT, SEND, DISCARD} state_t;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  wcnt, rptr, len_q;
    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic              in_rst, acc, rdy, req, eop_hit;

    assign in_rst  = !rstn || sw_rst;
    assign acc     = bus.s_valid && rdy;
    assign eop_hit = (rptr == len_q - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (in_rst) state <= COLLECT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        req       = 1'b0;
        case (state)
            COLLECT: begin
                rdy = 1'b1;
                if (acc) begin
                    if (bus.s_last)                          state_nxt = SEND;
                    else if (wcnt == LEN_W'(BUF_DEPTH - 1)) state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                rdy = 1'b1;
                if (acc && bus.s_last) state_nxt = COLLECT;
            end
            SEND: begin
                // Gated by reset so the bus is quiet during the reset cycle itself.
                req = !bus.ram_full && !in_rst;
                if (req && eop_hit) state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (in_rst) begin
            wcnt         <= '0;
            rptr         <= '0;
            len_q        <= '0;
            pkt_sent_cnt <= '0;
            pkt_drop_cnt <= '0;
        end else begin
            case (state)
                COLLECT: if (acc) begin
                    wcnt <= wcnt + LEN_W'(1);
                    if (bus.s_last) len_q <= wcnt + LEN_W'(1);
                end
                DISCARD: if (acc && bus.s_last) begin
                    wcnt         <= '0;
                    pkt_drop_cnt <= pkt_drop_cnt + CNT_W'(1);
                end
                SEND: if (req) begin
                    if (eop_hit) begin
                        rptr         <= '0;
                        wcnt         <= '0;
                        pkt_sent_cnt <= pkt_sent_cnt + CNT_W'(1);
                    end else begin
                        rptr <= rptr + LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Buffer storage needs no reset; contents are only read after a full write.
    always_ff @(posedge clk) begin
        if (state == COLLECT && acc) mem[wcnt[AW-1:0]] <= bus.s_data;
    end

    assign bus.s_ready           = rdy;
    assign bus.enq_req           = req;
    assign bus.enq_in_sop        = req && (rptr == '0);
    assign bus.enq_in_eop        = req && eop_hit;
    assign bus.enq_pck_len_valid = req && (rptr == '0);
    assign bus.enq_pck_len_i     = in_rst ? '0 : len_q;
    assign bus.enq_wr_data_i     = (state == SEND && !in_rst) ? mem[rptr[AW-1:0]] : '0;
    assign busy                  = (state != COLLECT) || (wcnt != '0);
endmodule

// File: tb/tb_pkt_enq_framer.sv
// Directed bench for pkt_enq_framer: inputs change and outputs are checked on negedge.
module tb_pkt_enq_framer;
    localparam int DATA_W = 32, LEN_W = 12, BUF_DEPTH = 64, CNT_W = 16;

    logic clk = 1'b0;
    logic rstn, sw_rst;
    logic [CNT_W-1:0] pkt_sent_cnt, pkt_drop_cnt;
    logic busy;
    int tests = 0, fails = 0;
    int req_cycles = 0;

    always #5 clk = ~clk;

    pkt_enq_framer_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    pkt_enq_framer #(.DATA_W(DATA_W), .LEN_W(LEN_W), .BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .bus(bus),
        .pkt_sent_cnt(pkt_sent_cnt), .pkt_drop_cnt(pkt_drop_cnt), .busy(busy)
    );

    always @(negedge clk) if (bus.enq_req === 1'b1) req_cycles++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one packet; returns just after the edge that accepted the last word.
    task automatic send_pkt(input logic [DATA_W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            int wait_cyc = 0;
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data  = base + DATA_W'(i);
            bus.s_last  = (i == n - 1);
            while (bus.s_ready !== 1'b1 && wait_cyc < 200) begin
                @(negedge clk);
                wait_cyc++;
            end
            if (wait_cyc >= 200) chk("s_ready_timeout", 0, 1);
            @(posedge clk);
        end
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    // Checks one emitted word at the next negedge.
    task automatic exp_word(input string tag, input logic [DATA_W-1:0] d,
                            input logic sop, input logic eop, input logic [LEN_W-1:0] len);
        @(negedge clk);
        chk({tag, "_req"}, bus.enq_req, 1);
        chk({tag, "_data"}, bus.enq_wr_data_i, d);
        chk({tag, "_sop"}, bus.enq_in_sop, sop);
        chk({tag, "_eop"}, bus.enq_in_eop, eop);
        chk({tag, "_lenv"}, bus.enq_pck_len_valid, sop);
        chk({tag, "_len"}, bus.enq_pck_len_i, len);
        chk({tag, "_srdy"}, bus.s_ready, 0);
    endtask

    initial begin
        int snap;
        rstn = 1'b0; sw_rst = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.ram_full = 1'b0;

        // Reset
        @(negedge clk);
        chk("rst_req", bus.enq_req, 0);
        chk("rst_sop", bus.enq_in_sop, 0);
        @(negedge clk);
        chk("rst_sent", pkt_sent_cnt, 0);
        chk("rst_drop", pkt_drop_cnt, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_req", bus.enq_req, 0);
        chk("post_rst_len", bus.enq_pck_len_i, 0);
        chk("post_rst_srdy", bus.s_ready, 1);
        chk("post_rst_busy", busy, 0);

        // 1: 4-word packet
        send_pkt(32'hA0, 4);
        for (int k = 0; k < 4; k++)
            exp_word("t1", 32'hA0 + k, k == 0, k == 3, 4);
        @(negedge clk);
        chk("t1_idle_req", bus.enq_req, 0);
        chk("t1_idle_data", bus.enq_wr_data_i, 0);
        chk("t1_len_hold", bus.enq_pck_len_i, 4);
        chk("t1_srdy", bus.s_ready, 1);
        chk("t1_sent", pkt_sent_cnt, 1);

        // 2: single word
        send_pkt(32'h55, 1);
        exp_word("t2", 32'h55, 1, 1, 1);
        @(negedge clk);
        chk("t2_idle_req", bus.enq_req, 0);
        chk("t2_sent", pkt_sent_cnt, 2);

        // 3: 6 words with a 3-cycle ram_full stall after word 1
        snap = req_cycles;
        send_pkt(32'h30, 6);
        exp_word("t3_w0", 32'h30, 1, 0, 6);
        exp_word("t3_w1", 32'h31, 0, 0, 6);
        @(posedge clk); #1 bus.ram_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_stall_req", bus.enq_req, 0);
            chk("t3_stall_sop", bus.enq_in_sop, 0);
            chk("t3_stall_data", bus.enq_wr_data_i, 32'h32);
        end
        @(posedge clk); #1 bus.ram_full = 1'b0;
        for (int k = 2; k < 6; k++)
            exp_word("t3_w", 32'h30 + k, 0, k == 5, 6);
        @(negedge clk);
        chk("t3_idle_req", bus.enq_req, 0);
        chk("t3_req_cycles", req_cycles - snap, 6);
        chk("t3_sent", pkt_sent_cnt, 3);

        // 4: 70-word oversize packet is discarded, then a 2-word packet
        snap = req_cycles;
        send_pkt(32'h100, 70);
        @(negedge clk);
        chk("t4_no_req", req_cycles - snap, 0);
        chk("t4_drop", pkt_drop_cnt, 1);
        chk("t4_sent", pkt_sent_cnt, 3);
        chk("t4_busy", busy, 0);
        chk("t4_srdy", bus.s_ready, 1);
        send_pkt(32'h200, 2);
        exp_word("t4_w0", 32'h200, 1, 0, 2);
        exp_word("t4_w1", 32'h201, 0, 1, 2);
        @(negedge clk);
        chk("t4_sent2", pkt_sent_cnt, 4);

        // 5: exactly BUF_DEPTH words is legal
        send_pkt(32'h300, 64);
        for (int k = 0; k < 64; k++)
            exp_word("t5_w", 32'h300 + k, k == 0, k == 63, 64);
        @(negedge clk);
        chk("t5_sent", pkt_sent_cnt, 5);
        chk("t5_drop", pkt_drop_cnt, 1);

        // 6: soft reset mid-SEND
        send_pkt(32'h400, 5);
        exp_word("t6_w0", 32'h400, 1, 0, 5);
        exp_word("t6_w1", 32'h401, 0, 0, 5);
        @(posedge clk); #1 sw_rst = 1'b1;
        @(negedge clk);
        chk("t6_inrst_req", bus.enq_req, 0);
        chk("t6_inrst_data", bus.enq_wr_data_i, 0);
        @(posedge clk); #1 sw_rst = 1'b0;
        @(negedge clk);
        chk("t6_req", bus.enq_req, 0);
        chk("t6_sent", pkt_sent_cnt, 0);
        chk("t6_drop", pkt_drop_cnt, 0);
        chk("t6_srdy", bus.s_ready, 1);
        chk("t6_busy", busy, 0);
        chk("t6_len", bus.enq_pck_len_i, 0);
        send_pkt(32'h500, 3);
        exp_word("t6_n0", 32'h500, 1, 0, 3);
        exp_word("t6_n1", 32'h501, 0, 0, 3);
        exp_word("t6_n2", 32'h502, 0, 1, 3);
        @(negedge clk);
        chk("t6_sent2", pkt_sent_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pkt_enq_framer.md
Name: pkt_enq_framer

Overview:
Ingress framing stage that sits directly upstream of the packet processor with external memory and drives its enqueue port.
- Accepts a 32-bit word stream with valid/ready and a last-word flag, and stores one complete packet in an internal buffer while counting its length.
- Replays the packet on the enq_* bus with SOP, EOP, length and length-valid, gated by the processor's ram_full.
- Discards packets longer than the buffer and counts sent and dropped packets.

Parameters:
DATA_W, 32, data word width (matches enq_wr_data_i)
LEN_W, 12, packet length field width in words (matches enq_pck_len_i)
BUF_DEPTH, 64, packet buffer depth in words; maximum legal packet length
CNT_W, 16, statistics counter width

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
sw_rst  input  1  synchronous active-high soft reset, same effect as rstn
s_valid  input  1  upstream word valid
s_ready  output  1  framer can accept a word
s_data  input  DATA_W  upstream data word
s_last  input  1  upstream last word of packet
ram_full  input  1  processor full; stalls emission
enq_req  output  1  enqueue word valid
enq_in_sop  output  1  first word of packet
enq_in_eop  output  1  last word of packet
enq_wr_data_i  output  DATA_W  enqueue data
enq_pck_len_valid  output  1  enq_pck_len_i valid, asserted with SOP
enq_pck_len_i  output  LEN_W  packet length in words
pkt_sent_cnt  output  CNT_W  packets fully emitted
pkt_drop_cnt  output  CNT_W  oversize packets discarded
busy  output  1  state != COLLECT or word count != 0

Behaviour:
- Reset: rstn=0 or sw_rst=1 at a clock edge puts state in COLLECT, clears pointers, word count, length and both counters.
  - All enq_* outputs are 0 while in reset and on the cycle after.
  - Buffer contents are don't-care after reset.
  - Reset mid-packet abandons the packet silently; no counter increments.
- Handshake: a word transfers on a clock edge when s_valid && s_ready.
- COLLECT (s_ready=1):
  - Each accepted word is written to buf[wcnt] and wcnt increments.
  - Accepted word with s_last=1: length latches as wcnt+1 and state goes to SEND.
  - Accepted word with s_last=0 while wcnt==BUF_DEPTH-1 (buffer full, no last): state goes to DISCARD.
- DISCARD (s_ready=1):
  - Accepted words are dropped.
  - On an accepted s_last: pkt_drop_cnt increments, wcnt clears, state goes to COLLECT.
  - A packet of exactly BUF_DEPTH words, with last on word BUF_DEPTH, is legal and is sent.
- SEND (s_ready=0):
  - enq_req = !ram_full, combinational from state and ram_full.
  - enq_wr_data_i = buf[rptr], driven only while in SEND.
  - When enq_req=1 at a clock edge, rptr increments.
  - enq_in_sop=1 when rptr==0 and enq_req=1; enq_pck_len_valid mirrors enq_in_sop; enq_pck_len_i = latched length.
  - enq_in_eop=1 when rptr==length-1 and enq_req=1.
  - On the EOP edge: pkt_sent_cnt increments, rptr and wcnt clear, state goes to COLLECT.
  - s_ready rises the cycle after EOP.
- Single-word packet: SOP, EOP and len_valid are all asserted in the same cycle with length=1.
- Latency: the first enq word appears in the cycle after the edge that accepted s_last, provided ram_full=0.
- ram_full stall: enq_req drops to 0 in the same cycle. rptr, sop/eop state and data are held. Emission resumes at the held word with no duplication and no loss.
- enq_in_sop, enq_in_eop and enq_pck_len_valid are 0 whenever enq_req=0.
- enq_pck_len_i holds its last value outside SEND.
- Counters wrap modulo 2^CNT_W.
- Widths: length is computed in LEN_W bits; BUF_DEPTH must be ≤ 2^LEN_W-1.

Test Plan:
1. Reset, then a 4-word packet 0xA0..0xA3 with last on 0xA3, ram_full=0 -> one cycle after last:
   - enq_req high 4 cycles with data A0..A3
   - SOP and len_valid with len=4 on A0, EOP on A3
   - pkt_sent_cnt=1; s_ready low exactly 4 cycles.
2. 1-word packet 0x55 -> a single enq_req cycle with SOP=EOP=len_valid=1 and len=1.
3. 6-word packet with ram_full forced high for 3 cycles after the 2nd emitted word -> enq_req=0 for those 3 cycles, output sequence is exactly W0..W5, SOP and EOP once each.
4. 70-word packet (BUF_DEPTH=64) -> no enq_req activity, pkt_drop_cnt=1. The following 2-word packet is sent normally with len=2.
5. Exactly 64-word packet -> sent with len=64, pkt_drop_cnt unchanged.
6. sw_rst pulse during SEND after the 2nd of 5 words -> enq_req=0 the next cycle, counters=0, state COLLECT, s_ready=1. The next packet starts with SOP at its first word.
